// File: rtl/cmd_scheduler.sv
// cmd_scheduler: opcode decoder that runs one function unit at a time and owns uart_tx.
// Optional watchdog/abort path enabled by defining CMD_SCHED_TIMEOUT_EN.
module cmd_scheduler #(
    parameter int unsigned          N_UNITS        = 6,
    parameter logic [N_UNITS*8-1:0] OPCODES        = {8'h24, 8'h23, 8'h72, 8'h71, 8'h22, 8'h21},
    parameter logic [7:0]           NAK_BYTE       = 8'h15,
    parameter logic [31:0]          TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic                   clk_50mhz,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   tx_active,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic [N_UNITS-1:0]     unit_activate,
    input  logic [N_UNITS-1:0]     unit_done,
    input  logic [N_UNITS*8-1:0]   unit_tx_data,
    input  logic [N_UNITS-1:0]     unit_tx_start,
    output logic [7:0]             state_code,
    output logic                   timeout_err
);

    localparam int SW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_NAK,
        S_DRAIN
    } state_t;

    state_t               state_q, state_n;
    logic [SW-1:0]        sel_q, sel_n;
    logic [N_UNITS-1:0]   act_q, act_n;
    logic [7:0]           txd_q, txd_n;
    logic                 txs_q, txs_n;
    logic [7:0]           code_q, code_n;

    logic                 hit;
    logic [SW-1:0]        hit_idx;
    logic                 sel_done;
    logic                 sel_txs;
    logic [7:0]           sel_txd;
    logic                 wd_hit;
    logic                 accept;

    // Opcode lookup: scan downward so the lowest matching index is kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (rx_data == OPCODES[i*8 +: 8]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign sel_done = unit_done[sel_q];
    assign sel_txs  = unit_tx_start[sel_q];
    assign sel_txd  = unit_tx_data[{sel_q, 3'b000} +: 8];
    assign accept   = (state_q == S_IDLE) && rx_ready && hit;

`ifdef CMD_SCHED_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_n;
    logic        err_q, err_n;

    assign wd_hit = (cnt_q == TIMEOUT_CYCLES - 32'd1);

    // Watchdog count runs only in RUN; the error flag is sticky until the next valid opcode.
    always_comb begin
        cnt_n = '0;
        err_n = err_q;
        if (state_q == S_RUN) begin
            cnt_n = cnt_q + 32'd1;
        end
        if (accept) begin
            err_n = 1'b0;
        end else if (state_q == S_RUN && !sel_done && wd_hit) begin
            err_n = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            err_q <= err_n;
        end
    end

    assign timeout_err = err_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and registered-output logic for the scheduler FSM.
    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        act_n   = act_q;
        txd_n   = txd_q;
        txs_n   = 1'b0;
        code_n  = code_q;
        case (state_q)
            S_IDLE: begin
                code_n = 8'h00;
                if (rx_ready) begin
                    if (hit) begin
                        sel_n   = hit_idx;
                        act_n   = N_UNITS'(1) << hit_idx;
                        state_n = S_RUN;
                        code_n  = rx_data;
                    end else begin
                        state_n = S_NAK;
                        code_n  = 8'hEE;
                    end
                end
            end
            S_RUN: begin
                txd_n = sel_txd;
                txs_n = sel_txs;
                if (sel_done) begin
                    act_n   = '0;
                    txs_n   = 1'b0;
                    state_n = S_DRAIN;
                    code_n  = 8'h01;
                end else if (wd_hit) begin
                    act_n   = '0;
                    txs_n   = 1'b0;
                    state_n = S_NAK;
                    code_n  = 8'hEE;
                end
            end
            S_NAK: begin
                if (!tx_active) begin
                    txd_n   = NAK_BYTE;
                    txs_n   = 1'b1;
                    state_n = S_DRAIN;
                    code_n  = 8'h01;
                end
            end
            S_DRAIN: begin
                code_n = 8'h01;
                if (!rx_ready && !tx_active && !txs_q) begin
                    state_n = S_IDLE;
                    code_n  = 8'h00;
                end
            end
            default: begin
                state_n = S_DRAIN;
                act_n   = '0;
                code_n  = 8'h01;
            end
        endcase
    end

    // State and output registers; reset parks in DRAIN with every output low.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state_q <= S_DRAIN;
            sel_q   <= '0;
            act_q   <= '0;
            txd_q   <= '0;
            txs_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            act_q   <= act_n;
            txd_q   <= txd_n;
            txs_q   <= txs_n;
            code_q  <= code_n;
        end
    end

    assign unit_activate = act_q;
    assign tx_data       = txd_q;
    assign tx_start      = txs_q;
    assign state_code    = code_q;

endmodule
